symbol_fifo: RTL and testbench
==============================

Name: symbol_fifo

Overview:
- Elastic buffer directly downstream of the word-to-symbol gearbox.
- The gearbox has no backpressure, so this block accepts every symbol presented with in_valid. It stores the symbol together with its first/last frame tags in a DEPTH-entry FIFO.
- The FIFO is drained by the consumer through a valid/ready handshake.
- The block also checks first/last framing on the incoming stream and reports overflow drops.

Parameters:
- SYM_WIDTH, 7, width of one symbol; equals the gearbox output width.
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- CNT_WIDTH, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  symbol present this cycle (gearbox valid_out)
- in_data  input  SYM_WIDTH  symbol (gearbox data_out)
- in_first  input  1  first symbol of word; sampled only when in_valid=1
- in_last  input  1  last symbol of word; sampled only when in_valid=1
- out_valid  output  1  head entry available
- out_ready  input  1  consumer accepts head entry
- out_data  output  SYM_WIDTH  head symbol
- out_first  output  1  head entry first tag
- out_last  output  1  head entry last tag
- level  output  $clog2(DEPTH+1)  entries currently stored
- overflow  output  1  sticky; a symbol was dropped
- drop_cnt  output  CNT_WIDTH  dropped symbols, saturating at all-ones
- frame_err  output  1  sticky; first/last sequencing violated

Behaviour:
- Reset (clk edge with rst=1) forces the following; applies equally mid-operation and discards all stored entries:
  - read pointer = 0, write pointer = 0, level = 0
  - out_valid = 0, overflow = 0, drop_cnt = 0, frame_err = 0
  - internal in_frame = 0
- Storage: DEPTH x (SYM_WIDTH+2) array holding {last, first, data}. Not reset.
- Pointers: $clog2(DEPTH)+1 bits each. The extra wrap bit distinguishes full from empty.
  - full: addresses equal, wrap bits differ
  - empty: pointers fully equal
- Read fire = out_valid & out_ready; read pointer advances by one.
- Write accept = in_valid & (!full | read fire).
  - Full with a simultaneous read accepts the write.
  - On accept, the entry is stored and the write pointer advances; wrap-around is natural modulo 2*DEPTH.
- Drop = in_valid & full & !read fire.
  - Symbol discarded; overflow set to 1 and held until reset.
  - drop_cnt increments by 1 and stops at 2^CNT_WIDTH-1.
- level:
  - +1 on accept without read fire
  - -1 on read fire without accept
  - unchanged when both or neither occur
  - registered; equals write pointer minus read pointer
- out_valid = !empty, registered state.
  - Latency: symbol accepted on edge N is visible on out_valid/out_data after edge N when the FIFO was empty. This is 1 cycle; there is no fall-through within the same cycle.
- out_data, out_first, out_last = head entry when out_valid=1, otherwise forced to 0.
- Head entry and out_valid stay stable while out_valid=1 and out_ready=0.
- out_ready while empty has no effect.
- Frame check (internal in_frame flag), evaluated on every in_valid cycle, including dropped symbols:
  - in_first=1 while in_frame=1 → frame_err set.
  - in_first=0 while in_frame=0 → frame_err set.
  - After the check: in_frame becomes 0 if in_last=1; otherwise 1.
  - first and last on the same symbol is legal (single-symbol word).
- frame_err is sticky until reset.
- Cycles with in_valid=0 do not update in_frame.

Test Plan:
- Reset then idle 5 cycles → out_valid=0, level=0, out_data=0, overflow=0, drop_cnt=0, frame_err=0.
- Write 5 symbols 0x11,0x22,0x33,0x44,0x05 tagged first on the first symbol and last on the fifth, with out_ready=0; then assert out_ready → level reaches 5; output sequence matches with out_first on 0x11 and out_last on 0x05; level returns to 0; frame_err=0.
- DEPTH=16, out_ready=0, write 20 symbols → level=16, overflow=1, drop_cnt=4; draining yields exactly the first 16 symbols in order.
- Full FIFO with out_ready=1 and in_valid=1 in the same cycle → write accepted, level stays 16, drop_cnt unchanged.
- Symbol with in_first=1 while a word is open, and separately a symbol with in_first=0 after in_last → frame_err=1 and stays 1; reset clears it.
- 40 symbols written with out_ready toggling 1,0,1,0 across pointer wrap → output order and tags exact, no drops, no false full/empty at wrap boundaries.

Source files
------------

// File: rtl/symbol_fifo.sv
// Elastic buffer behind the word-to-symbol gearbox: stores {last, first, data} per symbol, drops on full.
// One cycle from write to out_valid (no fall-through); the input cannot be stalled, so overflow drops are counted.
module symbol_fifo #(
  parameter int SYM_WIDTH = 7,
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [SYM_WIDTH-1:0]         in_data,
  input  logic                         in_first,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SYM_WIDTH-1:0]         out_data,
  output logic                         out_first,
  output logic                         out_last,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
  output logic [CNT_WIDTH-1:0]         drop_cnt,
  output logic                         frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int EW = SYM_WIDTH + 2;

  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   wr_ptr_nxt;
  logic [AW:0]   rd_ptr_nxt;
  logic [EW-1:0] head;
  logic          full;
  logic          rd_fire;
  logic          wr_acc;
  logic          drop;
  logic          in_frame;

  // Extra pointer bit separates full (same address, other lap) from empty.
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign rd_fire = out_valid & out_ready;
  assign wr_acc  = in_valid & (~full | rd_fire);
  assign drop    = in_valid & full & ~rd_fire;

  assign wr_ptr_nxt = wr_ptr + (AW+1)'(wr_acc);
  assign rd_ptr_nxt = rd_ptr + (AW+1)'(rd_fire);

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr[AW-1:0]] <= {in_last, in_first, in_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      out_valid <= (wr_ptr_nxt != rd_ptr_nxt);
      case ({wr_acc, rd_fire})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1)
        drop_cnt <= drop_cnt + CNT_WIDTH'(1);
    end
  end

  // Framing is checked on every presented symbol, dropped or not.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_frame  <= 1'b0;
      frame_err <= 1'b0;
    end else if (in_valid) begin
      if (in_first == in_frame)
        frame_err <= 1'b1;
      in_frame <= ~in_last;
    end
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign out_data  = out_valid ? head[SYM_WIDTH-1:0] : '0;
  assign out_first = out_valid ? head[SYM_WIDTH]     : 1'b0;
  assign out_last  = out_valid ? head[SYM_WIDTH+1]   : 1'b0;

endmodule

// File: tb/tb_symbol_fifo.sv
// Randomized bench for symbol_fifo against a queue-based reference model.
module tb_symbol_fifo;
  localparam int SW = 7;
  localparam int D  = 16;
  localparam int CW = 8;
  localparam int LW = $clog2(D+1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [SW-1:0] in_data = '0;
  logic          in_first = 1'b0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [SW-1:0] out_data;
  logic          out_first;
  logic          out_last;
  logic [LW-1:0] level;
  logic          overflow;
  logic [CW-1:0] drop_cnt;
  logic          frame_err;

  symbol_fifo #(.SYM_WIDTH(SW), .DEPTH(D), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_first(out_first), .out_last(out_last),
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference state: contents as a queue, flags and counts as plain variables.
  logic [SW+1:0] mq[$];
  logic [SW+1:0] got[$];
  logic [SW+1:0] exp_q[$];
  int m_drops;
  bit m_ovf, m_ferr, m_open;

  task automatic reset_dut();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    mq.delete(); got.delete(); exp_q.delete();
    m_drops = 0; m_ovf = 0; m_ferr = 0; m_open = 0;
  endtask

  // Drive one cycle; records what the DUT hands out and what the model says it should.
  task automatic step(input bit iv, input logic [SW-1:0] d, input bit f, input bit l, input bit rdy);
    bit m_fire, m_full;
    in_valid = iv; in_data = d; in_first = f; in_last = l; out_ready = rdy;
    if (out_valid && out_ready) got.push_back({out_last, out_first, out_data});
    m_fire = rdy && (mq.size() > 0);
    m_full = (mq.size() == D);
    if (m_fire) exp_q.push_back(mq.pop_front());
    if (iv) begin
      if (!m_full || m_fire) mq.push_back({l, f, d});
      else begin
        m_ovf = 1;
        if (m_drops < (1 << CW) - 1) m_drops++;
      end
      if (f && m_open) m_ferr = 1;
      if (!f && !m_open) m_ferr = 1;
      m_open = !l;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3*D && mq.size() > 0; i++) step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
  endtask

  task automatic test_reset();
    reset_dut();
    repeat (5) step(0, '0, 0, 0, 0);
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (level !== '0) $display("FAIL reset_level got %0d want 0", level); else n_pass++;
    n_total++; if (out_data !== '0) $display("FAIL reset_out_data got %h want 0", out_data); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else n_pass++;
    n_total++; if (drop_cnt !== '0) $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); else n_pass++;
    n_total++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got %b want 0", frame_err); else n_pass++;
    // Mid-operation reset must discard stored entries.
    for (int i = 0; i < 6; i++) step(1, SW'(i + 3), i == 0, 0, 0);
    reset_dut();
    n_total++; if (out_valid !== 1'b0 || level !== '0) $display("FAIL midreset got valid=%b level=%0d want 0/0", out_valid, level); else n_pass++;
  endtask

  task automatic test_basic();
    logic [SW-1:0] vals [5] = '{7'h11, 7'h22, 7'h33, 7'h44, 7'h05};
    reset_dut();
    for (int i = 0; i < 5; i++) step(1, vals[i], i == 0, i == 4, 0);
    n_total++; if (level !== LW'(5)) $display("FAIL basic_level got %0d want 5", level); else n_pass++;
    n_total++; if (out_valid !== 1'b1 || out_data !== 7'h11 || out_first !== 1'b1)
      $display("FAIL basic_head got v=%b d=%h f=%b want 1/11/1", out_valid, out_data, out_first); else n_pass++;
    drain();
    n_total++; if (got.size() != 5) $display("FAIL basic_count got %0d want 5", got.size()); else n_pass++;
    for (int i = 0; i < got.size() && i < 5; i++) begin
      n_total++;
      if (got[i] !== {i == 4, i == 0, vals[i]}) $display("FAIL basic_sym%0d got %h want %h", i, got[i], {i == 4, i == 0, vals[i]});
      else n_pass++;
    end
    n_total++; if (level !== '0) $display("FAIL basic_level_end got %0d want 0", level); else n_pass++;
    n_total++; if (frame_err !== 1'b0) $display("FAIL basic_frame_err got %b want 0", frame_err); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [SW-1:0] d [21];
    reset_dut();
    for (int i = 0; i < 21; i++) d[i] = SW'($urandom);
    for (int i = 0; i < 20; i++) step(1, d[i], i == 0, i == 19, 0);
    n_total++; if (level !== LW'(16)) $display("FAIL ovf_level got %0d want 16", level); else n_pass++;
    n_total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else n_pass++;
    n_total++; if (drop_cnt !== CW'(4)) $display("FAIL ovf_drop_cnt got %0d want 4", drop_cnt); else n_pass++;
    // Full plus simultaneous read: write is accepted, nothing dropped.
    step(1, d[20], 1, 1, 1);
    n_total++; if (level !== LW'(16)) $display("FAIL fullrw_level got %0d want 16", level); else n_pass++;
    n_total++; if (drop_cnt !== CW'(4)) $display("FAIL fullrw_drop_cnt got %0d want 4", drop_cnt); else n_pass++;
    drain();
    n_total++; if (got.size() != 17) $display("FAIL ovf_count got %0d want 17", got.size()); else n_pass++;
    for (int i = 0; i < got.size() && i < 17; i++) begin
      n_total++;
      if (got[i][SW-1:0] !== d[i < 16 ? i : 20]) $display("FAIL ovf_sym%0d got %h want %h", i, got[i][SW-1:0], d[i < 16 ? i : 20]);
      else n_pass++;
    end
    n_total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow); else n_pass++;
  endtask

  task automatic test_frame_err();
    reset_dut();
    step(1, 7'h01, 1, 0, 1);
    step(1, 7'h02, 1, 0, 1);
    n_total++; if (frame_err !== 1'b1) $display("FAIL ferr_first_in_word got %b want 1", frame_err); else n_pass++;
    repeat (4) step(1, 7'h03, 1, 1, 1);
    n_total++; if (frame_err !== 1'b1) $display("FAIL ferr_sticky got %b want 1", frame_err); else n_pass++;
    reset_dut();
    n_total++; if (frame_err !== 1'b0) $display("FAIL ferr_reset got %b want 0", frame_err); else n_pass++;
    step(1, 7'h04, 1, 1, 1);
    n_total++; if (frame_err !== 1'b0) $display("FAIL ferr_single_sym got %b want 0", frame_err); else n_pass++;
    step(1, 7'h05, 0, 0, 1);
    n_total++; if (frame_err !== 1'b1) $display("FAIL ferr_no_first got %b want 1", frame_err); else n_pass++;
    reset_dut();
  endtask

  task automatic test_wrap();
    int len;
    int pos;
    int bad;
    reset_dut();
    len = 1; pos = 0; bad = 0;
    for (int c = 0; c < 80; c++) begin
      if (c % 2 == 1) begin
        if (pos == 0) len = $urandom_range(1, 4);
        step(1, SW'($urandom), pos == 0, pos == len - 1, c % 4 == 1);
        pos = (pos == len - 1) ? 0 : pos + 1;
      end else begin
        step(0, '0, 0, 0, c % 4 == 0);
      end
      if (out_valid !== (mq.size() > 0) || level !== LW'(mq.size())) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL wrap_state got %0d bad cycles want 0", bad); else n_pass++;
    drain();
    n_total++; if (got.size() != 40 || exp_q.size() != 40) $display("FAIL wrap_count got %0d want 40", got.size()); else n_pass++;
    bad = 0;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) bad++;
    n_total++; if (bad != 0) $display("FAIL wrap_order got %0d wrong entries want 0", bad); else n_pass++;
    n_total++; if (drop_cnt !== '0 || overflow !== 1'b0) $display("FAIL wrap_drops got %0d/%b want 0/0", drop_cnt, overflow); else n_pass++;
    n_total++; if (frame_err !== 1'b0) $display("FAIL wrap_frame_err got %b want 0", frame_err); else n_pass++;
  endtask

  task automatic test_random();
    int bad_lvl, bad_flags, bad_data;
    reset_dut();
    bad_lvl = 0; bad_flags = 0; bad_data = 0;
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 9) < 7, SW'($urandom), $urandom_range(0, 7) == 0 ? m_open : !m_open,
           $urandom_range(0, 2) == 0, $urandom_range(0, 9) < (c < 200 ? 4 : 7));
      if (level !== LW'(mq.size()) || out_valid !== (mq.size() > 0)) bad_lvl++;
      if (overflow !== m_ovf || drop_cnt !== CW'(m_drops) || frame_err !== m_ferr) bad_flags++;
      if (mq.size() > 0 && {out_last, out_first, out_data} !== mq[0]) bad_data++;
    end
    n_total++; if (bad_lvl != 0) $display("FAIL rand_level got %0d bad cycles want 0", bad_lvl); else n_pass++;
    n_total++; if (bad_flags != 0) $display("FAIL rand_flags got %0d bad cycles want 0", bad_flags); else n_pass++;
    n_total++; if (bad_data != 0) $display("FAIL rand_head got %0d bad cycles want 0", bad_data); else n_pass++;
    drain();
    n_total++; if (got.size() != exp_q.size()) $display("FAIL rand_count got %0d want %0d", got.size(), exp_q.size()); else n_pass++;
    bad_data = 0;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) bad_data++;
    n_total++; if (bad_data != 0) $display("FAIL rand_order got %0d wrong entries want 0", bad_data); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_frame_err();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end

endmodule
